// File: rtl/pwm_duty_ramp_ctrl.sv
// Ramps the PWMGenerator duty word one LSB per StepPeriods PWM periods toward a handshaken target.
// Optional period watchdog enabled by defining PWM_RAMP_WDOG_EN.
module pwm_duty_ramp_ctrl #(
    parameter int Size           = 3,
    parameter int StepPeriods    = 4,
    parameter int ClockPeriod_ns = 20,
    parameter int PWMPeriod_ns   = 20_000
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [Size-1:0] Target,
    input  logic            TargetValid,
    output logic            TargetReady,
    input  logic            Synch,
    output logic [Size-1:0] Data,
    output logic            Busy,
    output logic            Done,
    output logic            Fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int            CW       = $clog2(StepPeriods + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(StepPeriods - 1);

    if (StepPeriods < 1 || PWMPeriod_ns < ClockPeriod_ns) begin : g_param_check
        $error("pwm_duty_ramp_ctrl: illegal StepPeriods or PWM/clock period");
    end

`ifdef PWM_RAMP_WDOG_EN
    // A healthy generator marks a period well within two PWM periods.
    localparam int            WDOG_CYCLES = 2 * PWMPeriod_ns / ClockPeriod_ns;
    localparam int            WW          = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LIM    = WW'(WDOG_CYCLES);
    logic [WW-1:0] wdog_r;
    logic [WW-1:0] wdog_n_s;
`endif

    state_t          state_r;
    state_t          state_n_s;
    logic [Size-1:0] data_r;
    logic [Size-1:0] data_n_s;
    logic [Size-1:0] step_data_s;
    logic [Size-1:0] target_q_r;
    logic [Size-1:0] target_n_s;
    logic [CW-1:0]   period_cnt_r;
    logic [CW-1:0]   cnt_n_s;
    logic            synch_q_r;
    logic            synch_edge_s;
    logic            accept_s;
    logic            ready_r;
    logic            busy_r;
    logic            done_r;
    logic            fault_r;
    logic            fault_n_s;

    assign synch_edge_s = Synch & ~synch_q_r;
    assign accept_s     = TargetValid & ready_r;

    // Next-state, duty and period-counter logic.
    always_comb begin
        state_n_s  = state_r;
        data_n_s   = data_r;
        target_n_s = target_q_r;
        cnt_n_s    = period_cnt_r;
        fault_n_s  = fault_r;
`ifdef PWM_RAMP_WDOG_EN
        wdog_n_s   = wdog_r;
`endif
        if (data_r < target_q_r) begin
            step_data_s = data_r + Size'(1);
        end else begin
            step_data_s = data_r - Size'(1);
        end
        case (state_r)
            IDLE: begin
                cnt_n_s = {CW{1'b0}};
                if (accept_s) begin
                    target_n_s = Target;
                    if (Target == data_r) begin
                        state_n_s = DONE;
                    end else begin
                        state_n_s = RAMP;
`ifdef PWM_RAMP_WDOG_EN
                        wdog_n_s  = {WW{1'b0}};
`endif
                    end
                end else begin
                    state_n_s = IDLE;
                end
            end
            RAMP: begin
                if (synch_edge_s) begin
`ifdef PWM_RAMP_WDOG_EN
                    wdog_n_s = {WW{1'b0}};
`endif
                    if (period_cnt_r == CNT_LAST) begin
                        cnt_n_s  = {CW{1'b0}};
                        data_n_s = step_data_s;
                        if (step_data_s == target_q_r) begin
                            state_n_s = DONE;
                        end else begin
                            state_n_s = RAMP;
                        end
                    end else begin
                        cnt_n_s = period_cnt_r + CW'(1);
                    end
`ifdef PWM_RAMP_WDOG_EN
                end else if (wdog_r == WDOG_LIM) begin
                    // Lost Synch: freeze duty and refuse targets until Reset.
                    fault_n_s = 1'b1;
                    state_n_s = IDLE;
                    cnt_n_s   = {CW{1'b0}};
                end else begin
                    wdog_n_s = wdog_r + WW'(1);
                end
`else
                end else begin
                    cnt_n_s = period_cnt_r;
                end
`endif
            end
            DONE: begin
                state_n_s = IDLE;
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // State and registered outputs; outputs reflect the state being entered.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r      <= IDLE;
            data_r       <= {Size{1'b0}};
            target_q_r   <= {Size{1'b0}};
            period_cnt_r <= {CW{1'b0}};
            synch_q_r    <= 1'b0;
            ready_r      <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            fault_r      <= 1'b0;
`ifdef PWM_RAMP_WDOG_EN
            wdog_r       <= {WW{1'b0}};
`endif
        end else begin
            state_r      <= state_n_s;
            data_r       <= data_n_s;
            target_q_r   <= target_n_s;
            period_cnt_r <= cnt_n_s;
            synch_q_r    <= Synch;
            ready_r      <= (state_n_s == IDLE) & ~fault_n_s;
            busy_r       <= (state_n_s == RAMP);
            done_r       <= (state_n_s == DONE);
            fault_r      <= fault_n_s;
`ifdef PWM_RAMP_WDOG_EN
            wdog_r       <= wdog_n_s;
`endif
        end
    end

    assign Data        = data_r;
    assign TargetReady = ready_r;
    assign Busy        = busy_r;
    assign Done        = done_r;
    assign Fault       = fault_r;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Scoreboard bench for pwm_duty_ramp_ctrl: expected duty steps and Done pulses are queued
// with the Synch edge index they must occur on; a negedge monitor pops and compares.
module tb_pwm_duty_ramp_ctrl;

    localparam int SZ = 3;
    localparam int SP = 4;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [SZ-1:0] Target;
    logic          TargetValid;
    logic          TargetReady;
    logic          Synch;
    logic [SZ-1:0] Data;
    logic          Busy;
    logic          Done;
    logic          Fault;

    always #5 Clock = ~Clock;

    pwm_duty_ramp_ctrl #(
        .Size(SZ),
        .StepPeriods(SP),
        .ClockPeriod_ns(20),
        .PWMPeriod_ns(20_000)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Target(Target),
        .TargetValid(TargetValid),
        .TargetReady(TargetReady),
        .Synch(Synch),
        .Data(Data),
        .Busy(Busy),
        .Done(Done),
        .Fault(Fault)
    );

    typedef struct {
        bit            is_done;
        logic [SZ-1:0] val;
        int            edge_n;
    } exp_t;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            edge_cnt = 0;
    bit            mon_en   = 1'b0;
    logic [SZ-1:0] prev_data;

    function automatic void push(bit d, int v, int e);
        exp_t x;
        x.is_done = d;
        x.val     = SZ'(v);
        x.edge_n  = e;
        exp_q.push_back(x);
    endfunction

    // Expected steps from -> to, one per SP Synch edges, then Done on the final edge.
    function automatic void push_ramp(int from, int to);
        int n;
        n = (to > from) ? (to - from) : (from - to);
        for (int k = 1; k <= n; k++) begin
            push(1'b0, (to > from) ? (from + k) : (from - k), SP * k);
        end
        push(1'b1, to, SP * n);
    endfunction

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic void sb_event(bit d, logic [SZ-1:0] v);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: got %s=%0d at edge %0d, expected no event",
                     d ? "done" : "data", v, edge_cnt);
        end else begin
            e = exp_q.pop_front();
            if (e.is_done == d && e.val == v && (e.edge_n < 0 || e.edge_n == edge_cnt))
                n_pass++;
            else
                $display("FAIL sb_event: got %s=%0d at edge %0d, expected %s=%0d at edge %0d",
                         d ? "done" : "data", v, edge_cnt,
                         e.is_done ? "done" : "data", e.val, e.edge_n);
        end
    endfunction

    // Monitor: every Data change and every Done pulse is a DUT event.
    always @(negedge Clock) begin
        if (mon_en) begin
            if (Data !== prev_data) begin
                sb_event(1'b0, Data);
                prev_data = Data;
            end
            if (Done === 1'b1) sb_event(1'b1, Data);
        end
    end

    task automatic accept(input int t);
        @(negedge Clock);
        Target      = SZ'(t);
        TargetValid = 1'b1;
        edge_cnt    = 0;
        @(negedge Clock);
        TargetValid = 1'b0;
    endtask

    // Each PWM period: Synch high for 2 cycles (one edge), low for 3.
    task automatic synch_periods(input int n);
        repeat (n) begin
            @(negedge Clock);
            Synch = 1'b1;
            edge_cnt++;
            @(negedge Clock);
            @(negedge Clock);
            Synch = 1'b0;
            repeat (2) @(negedge Clock);
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge Clock);
            t++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        Reset       = 1'b1;
        Target      = '0;
        TargetValid = 1'b0;
        Synch       = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        chk("rst_data", Data, 0);
        chk("rst_ready", TargetReady, 1);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_fault", Fault, 0);
        prev_data = Data;
        mon_en    = 1'b1;

        // Ramp up 0 -> 6.
        push_ramp(0, 6);
        accept(6);
        chk("up_busy", Busy, 1);
        chk("up_ready", TargetReady, 0);
        synch_periods(24);
        wait_drain("up");
        chk("up_ready_after", TargetReady, 1);
        chk("up_busy_after", Busy, 0);

        // Ramp down 6 -> 2 with a stray target mid-ramp.
        push_ramp(6, 2);
        accept(2);
        synch_periods(6);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            Target      = 3'd7;
            TargetValid = 1'b1;
            chk("stray_ready", TargetReady, 0);
        end
        @(negedge Clock);
        TargetValid = 1'b0;
        Target      = '0;
        synch_periods(10);
        wait_drain("down");
        chk("down_data", Data, 2);

        // Target equal to current duty: immediate Done, no Busy.
        push_ramp(2, 2);
        accept(2);
        chk("same_busy", Busy, 0);
        chk("same_done", Done, 1);
        @(negedge Clock);
        chk("same_done_clr", Done, 0);
        chk("same_ready", TargetReady, 1);
        wait_drain("same");

        // Down to the lower boundary.
        push_ramp(2, 0);
        accept(0);
        synch_periods(8);
        wait_drain("to_zero");

        // Reset mid-ramp once Data reaches 3.
        push(1'b0, 1, 4);
        push(1'b0, 2, 8);
        push(1'b0, 3, 12);
        accept(6);
        synch_periods(12);
        wait_drain("pre_reset");
        push(1'b0, 0, -1);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk("midrst_data", Data, 0);
        chk("midrst_busy", Busy, 0);
        chk("midrst_ready", TargetReady, 1);
        chk("midrst_done", Done, 0);
        synch_periods(4);
        push_ramp(0, 1);
        accept(1);
        synch_periods(4);
        wait_drain("post_reset");

        // Synch stalls during a ramp.
        accept(3);
        repeat (2100) @(negedge Clock);
`ifdef PWM_RAMP_WDOG_EN
        chk("wdog_fault", Fault, 1);
        chk("wdog_busy", Busy, 0);
        chk("wdog_ready", TargetReady, 0);
`else
        chk("wdog_fault", Fault, 0);
        chk("wdog_busy", Busy, 1);
        chk("wdog_ready", TargetReady, 0);
`endif
        chk("wdog_data", Data, 1);
        push(1'b0, 0, -1);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk("wdog_rst_fault", Fault, 0);
        chk("wdog_rst_ready", TargetReady, 1);
        wait_drain("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
